// File: rtl/ex_pkg.sv
// Shared types for the MIPS execute stage: opcodes, default widths and MDU state.
package ex_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RDW_DEF  = 5;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLT   = 4'd4,
    OP_BEQ   = 4'd5,
    OP_BNE   = 4'd6,
    OP_NOR   = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  mdu_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, divisor;
  logic [3:0]      op_r;
  logic            load, step, is_div;
  logic [XLEN:0]   add_sum, shifted, diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nxt;
  end

  // busy depends only on start/abort/state so ex_stall never sees operand values
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          load      = 1'b1;
          busy      = 1'b1;
          state_nxt = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == CW'(XLEN - 1)) state_nxt = MDU_DONE;
      end
      MDU_DONE: begin
        done      = 1'b1;
        state_nxt = MDU_IDLE;
      end
      default: state_nxt = MDU_IDLE;
    endcase
    if (abort) begin
      state_nxt = MDU_IDLE;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
    end
    if (rst) busy = 1'b0;
  end

  assign is_div  = (op_r == OP_DIVU) || (op_r == OP_REMU);
  assign add_sum = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
  assign shifted = {hi, lo[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // hi holds partial product / remainder, lo holds multiplier / quotient
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      divisor <= '0;
      cnt     <= '0;
      op_r    <= '0;
    end else if (load) begin
      hi      <= '0;
      lo      <= a;
      divisor <= b;
      cnt     <= '0;
      op_r    <= op;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        if (!diff[XLEN]) begin
          hi <= diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= shifted[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= add_sum[XLEN:1];
        lo <= {add_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  assign result = ((op_r == OP_MULHU) || (op_r == OP_REMU)) ? hi : lo;

endmodule

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: single-cycle ALU/branch resolution, optional iterative MDU,
// and the registered XM pipeline boundary.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned RDW    = RDW_DEF,
  parameter bit          MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dx_valid,
  input  logic [3:0]      dx_op,
  input  logic [XLEN-1:0] dx_a,
  input  logic [XLEN-1:0] dx_b,
  input  logic [15:0]     dx_imm,
  input  logic [XLEN-1:0] dx_npc,
  input  logic [RDW-1:0]  dx_rd,
  input  logic [XLEN-1:0] dx_md,
  input  logic            dx_memtoreg,
  input  logic            dx_regwrite,
  input  logic            dx_memread,
  input  logic            dx_memwrite,
  input  logic            dx_branch,
  output logic            ex_stall,
  output logic            xm_valid,
  output logic            xm_memtoreg,
  output logic            xm_regwrite,
  output logic            xm_memread,
  output logic            xm_memwrite,
  output logic            xm_branch,
  output logic [XLEN-1:0] xm_bt,
  output logic [XLEN-1:0] xm_alu_out,
  output logic [RDW-1:0]  xm_rd,
  output logic [XLEN-1:0] xm_md
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic            mdu_busy, mdu_done, bubble, taken;
  logic [XLEN-1:0] mdu_result, alu_res, br_off;
  logic [SHW-1:0]  shamt;

  generate
    if (MDU_EN) begin : g_mdu
      mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (dx_valid && is_mdu_op(dx_op)),
        .abort  (flush),
        .op     (dx_op),
        .a      (dx_a),
        .b      (dx_b),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
      );
    end else begin : g_no_mdu
      assign mdu_busy   = 1'b0;
      assign mdu_done   = 1'b0;
      assign mdu_result = '0;
    end
  endgenerate

  assign ex_stall = mdu_busy;
  assign shamt    = dx_b[SHW-1:0];

  // MDU opcodes fall to the ADD default; their real result comes from mdu_iter on DONE
  always_comb begin
    alu_res = dx_a + dx_b;
    case (dx_op)
      OP_SUB:  alu_res = dx_a - dx_b;
      OP_AND:  alu_res = dx_a & dx_b;
      OP_OR:   alu_res = dx_a | dx_b;
      OP_SLT:  alu_res = XLEN'($signed(dx_a) < $signed(dx_b));
      OP_BEQ:  alu_res = '0;
      OP_BNE:  alu_res = '0;
      OP_NOR:  alu_res = ~(dx_a | dx_b);
      OP_SLL:  alu_res = dx_a << shamt;
      OP_SRL:  alu_res = dx_a >> shamt;
      default: alu_res = dx_a + dx_b;
    endcase
  end

  assign taken  = dx_branch && (((dx_op == OP_BEQ) && (dx_a == dx_b)) ||
                                ((dx_op == OP_BNE) && (dx_a != dx_b)));
  assign br_off = XLEN'($signed({dx_imm, 2'b00}));
  assign bubble = !dx_valid || ex_stall || flush;

  // XM register: bubbles clear valid/controls but leave data fields holding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xm_valid    <= 1'b0;
      xm_memtoreg <= 1'b0;
      xm_regwrite <= 1'b0;
      xm_memread  <= 1'b0;
      xm_memwrite <= 1'b0;
      xm_branch   <= 1'b0;
      xm_bt       <= '0;
      xm_alu_out  <= '0;
      xm_rd       <= '0;
      xm_md       <= '0;
    end else if (bubble) begin
      xm_valid    <= 1'b0;
      xm_memtoreg <= 1'b0;
      xm_regwrite <= 1'b0;
      xm_memread  <= 1'b0;
      xm_memwrite <= 1'b0;
      xm_branch   <= 1'b0;
    end else begin
      xm_valid    <= 1'b1;
      xm_memtoreg <= dx_memtoreg;
      xm_regwrite <= dx_regwrite;
      xm_memread  <= dx_memread;
      xm_memwrite <= dx_memwrite;
      xm_branch   <= taken;
      xm_bt       <= dx_npc + br_off;
      xm_alu_out  <= mdu_done ? mdu_result : alu_res;
      xm_rd       <= dx_rd;
      xm_md       <= dx_md;
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Randomized self-checking bench for ex_stage_mdu (XLEN=32 and XLEN=8 instances)
// against an arithmetic reference model.
module tb_ex_stage_mdu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // XLEN=32 instance
  logic        flush, dx_valid, dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_branch;
  logic [3:0]  dx_op;
  logic [31:0] dx_a, dx_b, dx_npc, dx_md;
  logic [15:0] dx_imm;
  logic [4:0]  dx_rd;
  logic        ex_stall, xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch;
  logic [31:0] xm_bt, xm_alu_out, xm_md;
  logic [4:0]  xm_rd;

  // XLEN=8 instance
  logic       v8;
  logic [3:0] op8;
  logic [7:0] a8, b8, npc8, md8;
  logic       st8, xv8, xmtr8, xrw8, xmr8, xmw8, xbr8;
  logic [7:0] xbt8, xalu8, xmd8;
  logic [4:0] xrd8;

  ex_stage_mdu #(.XLEN(32), .RDW(5), .MDU_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .dx_valid(dx_valid), .dx_op(dx_op),
    .dx_a(dx_a), .dx_b(dx_b), .dx_imm(dx_imm), .dx_npc(dx_npc), .dx_rd(dx_rd),
    .dx_md(dx_md), .dx_memtoreg(dx_memtoreg), .dx_regwrite(dx_regwrite),
    .dx_memread(dx_memread), .dx_memwrite(dx_memwrite), .dx_branch(dx_branch),
    .ex_stall(ex_stall), .xm_valid(xm_valid), .xm_memtoreg(xm_memtoreg),
    .xm_regwrite(xm_regwrite), .xm_memread(xm_memread), .xm_memwrite(xm_memwrite),
    .xm_branch(xm_branch), .xm_bt(xm_bt), .xm_alu_out(xm_alu_out), .xm_rd(xm_rd),
    .xm_md(xm_md)
  );

  ex_stage_mdu #(.XLEN(8), .RDW(5), .MDU_EN(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .flush(1'b0), .dx_valid(v8), .dx_op(op8),
    .dx_a(a8), .dx_b(b8), .dx_imm(16'h0001), .dx_npc(npc8), .dx_rd(5'd3),
    .dx_md(md8), .dx_memtoreg(1'b0), .dx_regwrite(1'b1),
    .dx_memread(1'b0), .dx_memwrite(1'b0), .dx_branch(1'b0),
    .ex_stall(st8), .xm_valid(xv8), .xm_memtoreg(xmtr8),
    .xm_regwrite(xrw8), .xm_memread(xmr8), .xm_memwrite(xmw8),
    .xm_branch(xbr8), .xm_bt(xbt8), .xm_alu_out(xalu8), .xm_rd(xrd8),
    .xm_md(xmd8)
  );

  // Reference result straight from the opcode definitions
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5, 4'd6: return 32'd0;
      4'd7:  return ~(a | b);
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    dx_valid = 1'b1;
    dx_op    = op;
    dx_a     = a;
    dx_b     = b;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    present(4'd10, 32'h5, 32'h7);
    v8 = 1'b1; op8 = 4'd12;
    #1;
    vectors++;
    if ({xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_branch, xm_bt, xm_alu_out, xm_rd, xm_md} !== '0) begin
      miscompares++; $display("FAIL reset_outs32: got alu=%h bt=%h valid=%b expected all zero", xm_alu_out, xm_bt, xm_valid);
    end
    vectors++;
    if (ex_stall !== 1'b0 || st8 !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b/%b expected 0/0", ex_stall, st8);
    end
    dx_valid = 1'b0; v8 = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    vectors++;
    if (xm_valid !== 1'b0 || xv8 !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_valid: got %b/%b expected 0/0", xm_valid, xv8);
    end
  endtask

  task automatic test_alu_directed();
    logic [3:0]  ops [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    logic [31:0] exs [3];
    ops = '{4'd0, 4'd4, 4'd9};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    bs  = '{32'd1, 32'd1, 32'd31};
    exs = '{32'd0, 32'd1, 32'd1};
    for (int i = 0; i < 3; i++) begin
      present(ops[i], as[i], bs[i]);
      tick();
      vectors++;
      if (xm_valid !== 1'b1 || xm_alu_out !== exs[i]) begin
        miscompares++; $display("FAIL alu_directed[%0d]: got valid=%b out=%h expected 1/%h", i, xm_valid, xm_alu_out, exs[i]);
      end
    end
  endtask

  task automatic test_branch();
    present(4'd5, 32'd5, 32'd5);
    dx_branch = 1'b1; dx_npc = 32'h100; dx_imm = 16'hFFFF;
    tick();
    vectors++;
    if (xm_branch !== 1'b1 || xm_bt !== 32'hFC || xm_alu_out !== 32'd0) begin
      miscompares++; $display("FAIL beq_taken: got br=%b bt=%h out=%h expected 1/000000fc/0", xm_branch, xm_bt, xm_alu_out);
    end
    dx_op = 4'd6;
    tick();
    vectors++;
    if (xm_branch !== 1'b0 || xm_bt !== 32'hFC) begin
      miscompares++; $display("FAIL bne_not_taken: got br=%b bt=%h expected 0/000000fc", xm_branch, xm_bt);
    end
    dx_branch = 1'b0;
  endtask

  task automatic test_alu_random();
    logic [3:0]  op;
    logic [31:0] a, b, exp_bt, held;
    logic        exp_br;
    logic [9:0]  exp_ctl;
    int          r, off;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        held = xm_alu_out;
        present(4'($urandom_range(0, 9)), $urandom, $urandom);
        dx_valid = 1'b0;
        tick();
        vectors++;
        if (xm_valid !== 1'b0 || xm_branch !== 1'b0 || xm_alu_out !== held) begin
          miscompares++; $display("FAIL bubble_hold: got valid=%b out=%h expected 0/%h", xm_valid, xm_alu_out, held);
        end
      end
      r  = $urandom_range(0, 11);
      op = (r < 10) ? 4'(r) : 4'(r + 4);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom);
      present(op, a, b);
      {dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_branch} = 5'($urandom);
      dx_rd = 5'($urandom); dx_md = $urandom; dx_npc = $urandom; dx_imm = 16'($urandom);
      off     = $signed(dx_imm);
      exp_bt  = dx_npc + 32'(off * 4);
      exp_br  = dx_branch && ((op == 4'd5 && a == b) || (op == 4'd6 && a != b));
      exp_ctl = {1'b1, dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_rd};
      #1;
      vectors++;
      if (ex_stall !== 1'b0) begin
        miscompares++; $display("FAIL alu_no_stall: op=%0d got %b expected 0", op, ex_stall);
      end
      tick();
      vectors++;
      if (xm_alu_out !== ref_result(op, a, b)) begin
        miscompares++; $display("FAIL alu_rand: op=%0d a=%h b=%h got %h expected %h", op, a, b, xm_alu_out, ref_result(op, a, b));
      end
      vectors++;
      if (xm_branch !== exp_br || xm_bt !== exp_bt) begin
        miscompares++; $display("FAIL branch_rand: op=%0d got br=%b bt=%h expected %b/%h", op, xm_branch, xm_bt, exp_br, exp_bt);
      end
      vectors++;
      if ({xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_rd} !== exp_ctl || xm_md !== dx_md) begin
        miscompares++; $display("FAIL ctl_rand: got ctl=%h md=%h expected %h/%h", {xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_rd}, xm_md, exp_ctl, dx_md);
      end
    end
    dx_valid = 1'b0;
    dx_branch = 1'b0;
  endtask

  // Back-to-back MDU ops: each new op is presented right after the previous result lands
  task automatic test_mdu();
    logic [3:0]  ops [14];
    logic [31:0] as  [14];
    logic [31:0] bs  [14];
    logic [31:0] exp;
    int          stalls;
    ops[0:5] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13};
    as[0:5]  = '{32'h10000, 32'h10000, 32'd100, 32'd100, 32'hDEAD_BEEF, 32'd9};
    bs[0:5]  = '{32'h10000, 32'h10000, 32'd7, 32'd7, 32'd0, 32'd0};
    for (int i = 6; i < 14; i++) begin
      ops[i] = 4'($urandom_range(10, 13));
      as[i]  = $urandom;
      case ($urandom_range(0, 3))
        0:       bs[i] = 32'd0;
        1:       bs[i] = 32'($urandom_range(1, 1000));
        default: bs[i] = $urandom;
      endcase
    end
    for (int i = 0; i < 14; i++) begin
      exp = ref_result(ops[i], as[i], bs[i]);
      present(ops[i], as[i], bs[i]);
      dx_rd = 5'(i);
      stalls = 0;
      #1;
      while (ex_stall === 1'b1 && stalls < 100) begin
        if (stalls > 0) begin
          vectors++;
          if (xm_valid !== 1'b0) begin
            miscompares++; $display("FAIL mdu_stall_bubble[%0d]: cycle %0d got valid=%b expected 0", i, stalls, xm_valid);
          end
        end
        stalls++;
        @(posedge clk);
        #2;
      end
      vectors++;
      if (stalls != 33) begin
        miscompares++; $display("FAIL mdu_stall_len[%0d]: got %0d cycles expected 33", i, stalls);
      end
      tick();
      vectors++;
      if (xm_valid !== 1'b1 || xm_alu_out !== exp || xm_rd !== 5'(i)) begin
        miscompares++; $display("FAIL mdu_result[%0d]: op=%0d a=%h b=%h got valid=%b out=%h expected 1/%h", i, ops[i], as[i], bs[i], xm_valid, xm_alu_out, exp);
      end
    end
    dx_valid = 1'b0;
  endtask

  task automatic test_flush();
    present(4'd12, 32'd100, 32'd7);
    repeat (10) tick();
    flush = 1'b1;
    #1;
    vectors++;
    if (ex_stall !== 1'b0) begin
      miscompares++; $display("FAIL flush_stall_drop: got %b expected 0", ex_stall);
    end
    tick();
    vectors++;
    if (xm_valid !== 1'b0 || xm_regwrite !== 1'b0) begin
      miscompares++; $display("FAIL flush_bubble: got valid=%b expected 0", xm_valid);
    end
    flush = 1'b0;
    present(4'd0, 32'd3, 32'd4);
    dx_regwrite = 1'b1;
    tick();
    vectors++;
    if (xm_valid !== 1'b1 || xm_alu_out !== 32'd7) begin
      miscompares++; $display("FAIL add_after_flush: got valid=%b out=%h expected 1/7", xm_valid, xm_alu_out);
    end
    present(4'd1, 32'd9, 32'd2);
    flush = 1'b1;
    tick();
    vectors++;
    if (xm_valid !== 1'b0 || xm_alu_out !== 32'd7) begin
      miscompares++; $display("FAIL flush_alu: got valid=%b out=%h expected 0/7", xm_valid, xm_alu_out);
    end
    flush = 1'b0;
    dx_valid = 1'b0;
  endtask

  task automatic test_reset_mid_divu();
    int cycles;
    v8 = 1'b1; op8 = 4'd0; a8 = 8'd200; b8 = 8'd3;
    tick();
    vectors++;
    if (xv8 !== 1'b1 || xalu8 !== 8'd203) begin
      miscompares++; $display("FAIL add8: got valid=%b out=%h expected 1/cb", xv8, xalu8);
    end
    op8 = 4'd12;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({xv8, xmtr8, xrw8, xmr8, xmw8, xbr8, xbt8, xalu8, xrd8, xmd8} !== '0 || st8 !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid8: got valid=%b out=%h stall=%b expected all zero", xv8, xalu8, st8);
    end
    vectors++;
    if (xm_alu_out !== 32'd0 || xm_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid32: got out=%h expected 0", xm_alu_out);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if (st8 !== 1'b1) begin
      miscompares++; $display("FAIL restart_stall8: got %b expected 1", st8);
    end
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (xv8 !== 1'b1 && cycles < 50);
    vectors++;
    if (cycles != 10 || xalu8 !== 8'd66) begin
      miscompares++; $display("FAIL divu8_after_reset: got %0d cycles out=%0d expected 10/66", cycles, xalu8);
    end
    v8 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; dx_valid = 1'b0; dx_op = '0; dx_a = '0; dx_b = '0;
    dx_imm = '0; dx_npc = '0; dx_rd = '0; dx_md = '0;
    dx_memtoreg = 1'b0; dx_regwrite = 1'b0; dx_memread = 1'b0; dx_memwrite = 1'b0; dx_branch = 1'b0;
    v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; npc8 = 8'h10; md8 = 8'h55;
    test_reset();
    test_alu_directed();
    test_branch();
    test_alu_random();
    test_mdu();
    test_flush();
    test_reset_mid_divu();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised execute stage for the 5-stage MIPS pipeline, sitting between the decode/execute (DX) and execute/memory (XM) pipeline registers. It performs single-cycle ALU, shift and branch-resolution operations and adds an iterative multiply/divide unit that stalls upstream stages while it runs. It registers all XM-side outputs, including branch decision, branch target and forwarded store data.

## Interface
- XLEN, 32: datapath width; power of two, ≥ 8.
- RDW, 5: destination register index width.
- MDU_EN, 1: 0 removes the multiply/divide unit; ops 10–13 then behave as ADD.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of the instruction in EX.
- dx_valid  in  1  DX holds a real instruction.
- dx_op  in  4  operation code (see Operation).
- dx_a, dx_b  in  XLEN  operands.
- dx_imm  in  16  branch offset, in words.
- dx_npc  in  XLEN  PC+4 of the instruction.
- dx_rd  in  RDW  destination register.
- dx_md  in  XLEN  store data.
- dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_branch  in  1 each  control bits.
- ex_stall  out  1  combinational; while high, upstream stages hold DX stable.
- xm_valid  out  1  XM holds a real instruction.
- xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite  out  1 each  registered control bits.
- xm_branch  out  1  branch taken.
- xm_bt  out  XLEN  branch target.
- xm_alu_out  out  XLEN  result.
- xm_rd  out  RDW  destination register.
- xm_md  out  XLEN  store data.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR.
  - 4 SLT: signed a<b gives 1, otherwise 0.
  - 5 BEQ, 6 BNE: xm_alu_out is 0.
  - 7 NOR.
  - 8 SLL, 9 SRL: shift a by b[log2(XLEN)-1:0].
  - 10 MUL: low XLEN bits of the product.
  - 11 MULHU: high XLEN bits of the unsigned product.
  - 12 DIVU, 13 REMU.
  - 14–15: treated as ADD.
- All arithmetic is modulo 2^XLEN; no overflow traps.
- xm_branch = dx_branch & ((op==5 & a==b) | (op==6 & a!=b)).
- xm_bt = dx_npc + (sign-extend(dx_imm) << 2), truncated to XLEN.
- Divide by zero: DIVU returns all-ones; REMU returns dx_a.
- Bubble: xm_valid and all five xm control bits are 0; data outputs are don't-care but hold their previous value.
- A bubble is written when any of these holds: dx_valid=0, ex_stall=1, or flush=1.
- MDU FSM states:
  - IDLE: on dx_valid & MDU op & !flush, load operands, zero the counter, go to BUSY. ex_stall=1 in this cycle.
  - BUSY: one shift-add or restoring-subtract iteration per cycle; counter increments. After XLEN iterations, go to DONE. ex_stall=1.
  - DONE: ex_stall=0. The result and DX controls are registered into XM. Return to IDLE, which does not restart on the same, now consumed, instruction.
- flush in any state: FSM returns to IDLE, ex_stall falls the same cycle, and a bubble is written.
- rst: asynchronous. All outputs go to 0 and the FSM goes to IDLE.

## Timing
- Non-MDU ops: 1 cycle; XM updates on the edge that ends the cycle in which the op is presented.
- MDU ops:
  - ex_stall is high for XLEN+1 cycles: the IDLE accept cycle plus XLEN BUSY cycles.
  - The result reaches XM at the end of the DONE cycle: XLEN+2 cycles after first presentation.
  - Back-to-back MDU ops: the next op is accepted in the cycle after DONE.
- Upstream must keep all dx_* inputs constant while ex_stall=1; the behaviour is unspecified otherwise.
- ex_stall depends combinationally on dx_valid, dx_op, flush and FSM state only, never on dx_a or dx_b.
- Reset mid-operation aborts the MDU. ex_stall is 0 while rst is high.

## Structure
- Package ex_pkg holds:
  - the 4-bit opcode enum;
  - the default XLEN and RDW;
  - the MDU state enum (IDLE/BUSY/DONE);
  - an is_mdu_op() function.
- Sub-module mdu_iter contains:
  - the FSM, counter, accumulator/remainder and quotient registers;
  - the interface start, op, a, b, busy, done, result, abort.
- Only mdu_iter is generated when MDU_EN=1. The top level holds the ALU, branch logic and XM registers.

## Test plan
- Single-cycle ALU ops with XLEN=32:
  - ADD 0xFFFFFFFF+1 → xm_alu_out=0.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SRL 0x80000000 by 31 → 1.
- Branch: BEQ a=b=5, dx_branch=1, npc=0x100, imm=0xFFFF → xm_branch=1, xm_bt=0xFC. BNE with the same inputs → xm_branch=0.
- MUL 0x10000 × 0x10000 → ex_stall high for 33 cycles, then xm_alu_out=0. MULHU with the same operands → 1. xm_valid=0 throughout the stall.
- Division:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- flush asserted on BUSY cycle 10 → ex_stall drops that cycle and a bubble is written. The next ADD completes in 1 cycle with the correct result.
- rst pulse mid-DIVU → all outputs 0, FSM IDLE. A repeat of XLEN=8 DIVU 200/3 then yields 66 after 10 cycles.
